sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
Arbiter and command multiplexer for the single SDRAM command/address/data bus. It gives the bus to the init sequencer until init_done, then grants it to the auto-refresh, write or read engine. The order is fixed priority: refresh, then write, then read. Arbitration is non-preemptive: an operation keeps the bus until that engine returns its *_end pulse. It sits between the sdram_ar, sdram_init, sdram_write and sdram_read engines and the SDRAM pins.

Parameters:
CMD_NOP, 4'b0111, command {cs_n,ras_n,cas_n,we_n} driven when idle.
IDLE_BA, 2'b11, bank address driven when idle.
IDLE_ADDR, 12'hFFF, address driven when idle.
TIMEOUT_MAX, 16'd2047, cycles allowed per granted operation before forced release.

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst_n  in  1  asynchronous active-low reset
init_done  in  1  initialization complete, level
init_cmd / init_ba / init_addr  in  4/2/12  init engine bus
ar_req  in  1  refresh request, level until acknowledged
ar_end  in  1  refresh finished, 1-cycle pulse
ar_cmd / ar_ba / ar_addr  in  4/2/12  refresh engine bus
wr_req  in  1  write request, level
wr_end  in  1  write finished, 1-cycle pulse
wr_cmd / wr_ba / wr_addr  in  4/2/12  write engine bus
wr_sdram_en  in  1  write engine drives DQ this cycle
wr_sdram_data  in  16  write data
rd_req  in  1  read request, level
rd_end  in  1  read finished, 1-cycle pulse
rd_cmd / rd_ba / rd_addr  in  4/2/12  read engine bus
ar_en / wr_en / rd_en  out  1  grant, 1-cycle registered pulse
sdram_cke  out  1  clock enable
sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1  command pins
sdram_ba  out  2  bank address
sdram_addr  out  12  address
sdram_dq_out  out  16  DQ output data
sdram_dq_oe  out  1  DQ output enable
arb_timeout  out  1  1-cycle pulse on forced release

Behaviour:
- Reset values:
  - state INIT, timeout counter 0.
  - ar_en, wr_en, rd_en, arb_timeout, sdram_cke all 0.
  - Pins show CMD_NOP, IDLE_BA, IDLE_ADDR; sdram_dq_out 0; sdram_dq_oe 0.
- sdram_cke is registered: it goes to 1 on the first clock after reset is released and stays 1.
- State machine states: INIT, ARBIT, AREF, WRITE, READ.
- INIT:
  - Pins carry the init_* bus.
  - Move to ARBIT when init_done=1.
- ARBIT, evaluated each cycle:
  - ar_req=1 -> AREF.
  - else wr_req=1 -> WRITE.
  - else rd_req=1 -> READ.
  - With simultaneous requests the highest priority wins; the losers stay pending, which is legal because requests are level signals.
  - Pins show NOP, IDLE_BA, IDLE_ADDR.
- Grant pulse: the matching *_en is 1 for exactly the first cycle in AREF, WRITE or READ. It is registered together with the state transition.
  - The *_en is never held high. This prevents an engine from re-starting when it returns to its idle state in the same cycle as *_end.
- AREF, WRITE, READ:
  - Pins carry the owner's cmd/ba/addr through a combinational mux selected by the registered state, so the engine's cycle timing is preserved with zero added latency.
  - Return to ARBIT on the owner's *_end. *_end from a non-owner is ignored.
  - The cycle after *_end the state is ARBIT, and a new grant can be issued one cycle later.
- DQ:
  - sdram_dq_oe = (state==WRITE) && wr_sdram_en.
  - sdram_dq_out = wr_sdram_data while in WRITE, else 0.
- Timeout:
  - A 16-bit counter clears on entry to AREF, WRITE or READ and increments while in those states.
  - On reaching TIMEOUT_MAX: force state to ARBIT and pulse arb_timeout for 1 cycle.
  - When *_end and the timeout occur in the same cycle, *_end wins and there is no arb_timeout pulse.
- init_done dropping to 0 in any state causes an immediate return to INIT on the next clock. No grant is issued and pins follow the init bus.
- Reset asserted mid-operation: all registers return to reset values asynchronously, and pins show NOP at once.
- Refresh starvation bound: a pending ar_req waits at most one in-flight write or read plus 1 cycle.

Decomposition:
- Shared package sdram_pkg:
  - command encodings: NOP 0111, PRECHARGE 0010, AUTOREFRESH 0001, ACTIVE, READ, WRITE, MRS;
  - arbiter state typedef;
  - address/bank width constants.
- One sub-module, sdram_cmd_mux: a combinational select of cmd/ba/addr by owner. Everything else stays in sdram_arbit.

Test Plan:
- Reset, then init_done=1 after 20 cycles with init_cmd=0010 -> pins show 0010 during INIT, ARBIT by cycle 21, sdram_cke=1 from cycle 1.
- ar_req, wr_req, rd_req all rise in the same ARBIT cycle -> ar_en single pulse next cycle.
  - After ar_end: wr_en pulse 2 cycles later, then rd_en after wr_end.
  - wr_en and rd_en are never high together.
- In WRITE with wr_sdram_en=1 and data 16'hA5A5 -> sdram_dq_oe=1, sdram_dq_out=A5A5 in the same cycle. In READ the same inputs give oe=0.
- ar_req rises 3 cycles into a READ -> no ar_en until rd_end. AREF is entered the cycle after rd_end, and ar_cmd 0001 appears on the pins.
- Engine never pulses wr_end -> after TIMEOUT_MAX cycles arb_timeout pulses once, state returns to ARBIT, pins show 0111.
- Reset asserted mid-AREF -> pins show 0111 and all *_en are 0 immediately. After release the block waits in INIT until init_done.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, bus widths and arbiter states.
package sdram_pkg;

   localparam int unsigned CMD_W  = 4;
   localparam int unsigned BA_W   = 2;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DQ_W   = 16;

   // Command encodings as {cs_n, ras_n, cas_n, we_n}
   localparam logic [CMD_W-1:0] SDR_NOP       = 4'b0111;
   localparam logic [CMD_W-1:0] SDR_PRECHARGE = 4'b0010;
   localparam logic [CMD_W-1:0] SDR_AUTOREF   = 4'b0001;
   localparam logic [CMD_W-1:0] SDR_ACTIVE    = 4'b0011;
   localparam logic [CMD_W-1:0] SDR_READ      = 4'b0101;
   localparam logic [CMD_W-1:0] SDR_WRITE     = 4'b0100;
   localparam logic [CMD_W-1:0] SDR_MRS       = 4'b0000;

   localparam logic [BA_W-1:0]   SDR_IDLE_BA      = 2'b11;
   localparam logic [ADDR_W-1:0] SDR_IDLE_ADDR    = 12'hFFF;
   localparam logic [15:0]       SDR_TIMEOUT_MAX  = 16'd2047;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } arb_state_t;

   // True for the states in which an engine owns the bus
   function automatic logic is_op(input arb_state_t s);
      return (s == ST_AREF) || (s == ST_WRITE) || (s == ST_READ);
   endfunction

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational cmd/ba/addr select by current bus owner.
module sdram_cmd_mux
   import sdram_pkg::*;
#(
   parameter logic [CMD_W-1:0]  IDLE_CMD  = SDR_NOP,
   parameter logic [BA_W-1:0]   IDLE_BA   = SDR_IDLE_BA,
   parameter logic [ADDR_W-1:0] IDLE_ADDR = SDR_IDLE_ADDR
) (
   input  arb_state_t        i_sel,
   input  logic [CMD_W-1:0]  i_init_cmd,
   input  logic [BA_W-1:0]   i_init_ba,
   input  logic [ADDR_W-1:0] i_init_addr,
   input  logic [CMD_W-1:0]  i_ar_cmd,
   input  logic [BA_W-1:0]   i_ar_ba,
   input  logic [ADDR_W-1:0] i_ar_addr,
   input  logic [CMD_W-1:0]  i_wr_cmd,
   input  logic [BA_W-1:0]   i_wr_ba,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [CMD_W-1:0]  i_rd_cmd,
   input  logic [BA_W-1:0]   i_rd_ba,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [CMD_W-1:0]  o_cmd,
   output logic [BA_W-1:0]   o_ba,
   output logic [ADDR_W-1:0] o_addr
);

   // Route the owning engine's bus; idle pattern when nobody owns it
   always_comb begin
      o_cmd  = IDLE_CMD;
      o_ba   = IDLE_BA;
      o_addr = IDLE_ADDR;
      case (i_sel)
         ST_INIT: begin
            o_cmd  = i_init_cmd;
            o_ba   = i_init_ba;
            o_addr = i_init_addr;
         end
         ST_AREF: begin
            o_cmd  = i_ar_cmd;
            o_ba   = i_ar_ba;
            o_addr = i_ar_addr;
         end
         ST_WRITE: begin
            o_cmd  = i_wr_cmd;
            o_ba   = i_wr_ba;
            o_addr = i_wr_addr;
         end
         ST_READ: begin
            o_cmd  = i_rd_cmd;
            o_ba   = i_rd_ba;
            o_addr = i_rd_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: init until init_done, then fixed-priority
// refresh > write > read, non-preemptive with a per-operation timeout.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter logic [3:0]  CMD_NOP     = SDR_NOP,
   parameter logic [1:0]  IDLE_BA     = SDR_IDLE_BA,
   parameter logic [11:0] IDLE_ADDR   = SDR_IDLE_ADDR,
   parameter logic [15:0] TIMEOUT_MAX = SDR_TIMEOUT_MAX
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        init_done,
   input  logic [3:0]  init_cmd,
   input  logic [1:0]  init_ba,
   input  logic [11:0] init_addr,
   input  logic        ar_req,
   input  logic        ar_end,
   input  logic [3:0]  ar_cmd,
   input  logic [1:0]  ar_ba,
   input  logic [11:0] ar_addr,
   input  logic        wr_req,
   input  logic        wr_end,
   input  logic [3:0]  wr_cmd,
   input  logic [1:0]  wr_ba,
   input  logic [11:0] wr_addr,
   input  logic        wr_sdram_en,
   input  logic [15:0] wr_sdram_data,
   input  logic        rd_req,
   input  logic        rd_end,
   input  logic [3:0]  rd_cmd,
   input  logic [1:0]  rd_ba,
   input  logic [11:0] rd_addr,
   output logic        ar_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic        sdram_cke,
   output logic        sdram_cs_n,
   output logic        sdram_ras_n,
   output logic        sdram_cas_n,
   output logic        sdram_we_n,
   output logic [1:0]  sdram_ba,
   output logic [11:0] sdram_addr,
   output logic [15:0] sdram_dq_out,
   output logic        sdram_dq_oe,
   output logic        arb_timeout
);

   arb_state_t  r_state;
   arb_state_t  w_next;
   logic [15:0] r_cnt;
   logic        r_ar_en;
   logic        r_wr_en;
   logic        r_rd_en;
   logic        r_timeout;
   logic        r_cke;
   logic        w_owner_end;
   logic        w_timeout;
   logic        w_stay_op;
   logic [3:0]  w_mux_cmd;
   logic [1:0]  w_mux_ba;
   logic [11:0] w_mux_addr;

   // Next-state selection: init_done loss dominates, then owner end, then timeout
   always_comb begin
      w_next      = r_state;
      w_timeout   = 1'b0;
      w_owner_end = 1'b0;
      case (r_state)
         ST_AREF:  w_owner_end = ar_end;
         ST_WRITE: w_owner_end = wr_end;
         ST_READ:  w_owner_end = rd_end;
         default:  w_owner_end = 1'b0;
      endcase
      if (!init_done) begin
         w_next = ST_INIT;
      end else begin
         case (r_state)
            ST_INIT:  w_next = ST_ARBIT;
            ST_ARBIT: begin
               if (ar_req)      w_next = ST_AREF;
               else if (wr_req) w_next = ST_WRITE;
               else if (rd_req) w_next = ST_READ;
            end
            ST_AREF, ST_WRITE, ST_READ: begin
               if (w_owner_end) begin
                  w_next = ST_ARBIT;
               end else if (r_cnt == TIMEOUT_MAX) begin
                  w_next    = ST_ARBIT;
                  w_timeout = 1'b1;
               end
            end
            default: w_next = ST_INIT;
         endcase
      end
   end

   assign w_stay_op = is_op(r_state) && (w_next == r_state);

   // State, timeout counter, grant pulses and clock enable
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state   <= ST_INIT;
         r_cnt     <= '0;
         r_ar_en   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_timeout <= 1'b0;
         r_cke     <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_stay_op ? r_cnt + 16'd1 : '0;
         r_ar_en   <= (r_state == ST_ARBIT) && (w_next == ST_AREF);
         r_wr_en   <= (r_state == ST_ARBIT) && (w_next == ST_WRITE);
         r_rd_en   <= (r_state == ST_ARBIT) && (w_next == ST_READ);
         r_timeout <= w_timeout;
         r_cke     <= 1'b1;
      end
   end

   sdram_cmd_mux #(
      .IDLE_CMD  (CMD_NOP),
      .IDLE_BA   (IDLE_BA),
      .IDLE_ADDR (IDLE_ADDR)
   ) u_cmd_mux (
      .i_sel       (r_state),
      .i_init_cmd  (init_cmd),
      .i_init_ba   (init_ba),
      .i_init_addr (init_addr),
      .i_ar_cmd    (ar_cmd),
      .i_ar_ba     (ar_ba),
      .i_ar_addr   (ar_addr),
      .i_wr_cmd    (wr_cmd),
      .i_wr_ba     (wr_ba),
      .i_wr_addr   (wr_addr),
      .i_rd_cmd    (rd_cmd),
      .i_rd_ba     (rd_ba),
      .i_rd_addr   (rd_addr),
      .o_cmd       (w_mux_cmd),
      .o_ba        (w_mux_ba),
      .o_addr      (w_mux_addr)
   );

   // r_cke is cleared asynchronously by reset, so gating on it forces the
   // idle pattern onto the pins the moment reset asserts.
   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cke ? w_mux_cmd : CMD_NOP;
   assign sdram_ba     = r_cke ? w_mux_ba   : IDLE_BA;
   assign sdram_addr   = r_cke ? w_mux_addr : IDLE_ADDR;

   assign sdram_dq_oe  = (r_state == ST_WRITE) && wr_sdram_en;
   assign sdram_dq_out = (r_state == ST_WRITE) ? wr_sdram_data : '0;

   assign ar_en       = r_ar_en;
   assign wr_en       = r_wr_en;
   assign rd_en       = r_rd_en;
   assign arb_timeout = r_timeout;
   assign sdram_cke   = r_cke;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed self-checking bench for sdram_arbit.
module tb_sdram_arbit;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        init_done;
   logic [3:0]  init_cmd;
   logic [1:0]  init_ba;
   logic [11:0] init_addr;
   logic        ar_req, ar_end;
   logic [3:0]  ar_cmd;
   logic [1:0]  ar_ba;
   logic [11:0] ar_addr;
   logic        wr_req, wr_end;
   logic [3:0]  wr_cmd;
   logic [1:0]  wr_ba;
   logic [11:0] wr_addr;
   logic        wr_sdram_en;
   logic [15:0] wr_sdram_data;
   logic        rd_req, rd_end;
   logic [3:0]  rd_cmd;
   logic [1:0]  rd_ba;
   logic [11:0] rd_addr;
   logic        ar_en, wr_en, rd_en;
   logic        sdram_cke;
   logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [11:0] sdram_addr;
   logic [15:0] sdram_dq_out;
   logic        sdram_dq_oe;
   logic        arb_timeout;

   int n_checks = 0;
   int n_errors = 0;

   sdram_arbit dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .init_done     (init_done),
      .init_cmd      (init_cmd),
      .init_ba       (init_ba),
      .init_addr     (init_addr),
      .ar_req        (ar_req),
      .ar_end        (ar_end),
      .ar_cmd        (ar_cmd),
      .ar_ba         (ar_ba),
      .ar_addr       (ar_addr),
      .wr_req        (wr_req),
      .wr_end        (wr_end),
      .wr_cmd        (wr_cmd),
      .wr_ba         (wr_ba),
      .wr_addr       (wr_addr),
      .wr_sdram_en   (wr_sdram_en),
      .wr_sdram_data (wr_sdram_data),
      .rd_req        (rd_req),
      .rd_end        (rd_end),
      .rd_cmd        (rd_cmd),
      .rd_ba         (rd_ba),
      .rd_addr       (rd_addr),
      .ar_en         (ar_en),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .sdram_cke     (sdram_cke),
      .sdram_cs_n    (sdram_cs_n),
      .sdram_ras_n   (sdram_ras_n),
      .sdram_cas_n   (sdram_cas_n),
      .sdram_we_n    (sdram_we_n),
      .sdram_ba      (sdram_ba),
      .sdram_addr    (sdram_addr),
      .sdram_dq_out  (sdram_dq_out),
      .sdram_dq_oe   (sdram_dq_oe),
      .arb_timeout   (arb_timeout)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_pins(input string tag, input logic [3:0] cmd,
                             input logic [1:0] ba, input logic [11:0] addr);
      check({tag, "_cmd"}, {28'b0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'b0, cmd});
      check({tag, "_ba"}, {30'b0, sdram_ba}, {30'b0, ba});
      check({tag, "_addr"}, {20'b0, sdram_addr}, {20'b0, addr});
   endtask

   // Advance one clock; return at the following falling edge
   task automatic tick();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   // Write and read grants must never coincide
   always @(negedge sys_clk) check("excl_wr_rd", {31'b0, wr_en & rd_en}, 32'd0);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      sys_rst_n = 1'b0; init_done = 1'b0;
      init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 12'h400;
      ar_req = 1'b0; ar_end = 1'b0; ar_cmd = 4'b0001; ar_ba = 2'b00; ar_addr = 12'h400;
      wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 12'h0AB;
      rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 12'h0CD;
      wr_sdram_en = 1'b0; wr_sdram_data = 16'h0000;

      // Reset values
      #3;
      check_pins("rst", 4'b0111, 2'b11, 12'hFFF);
      check("rst_cke", {31'b0, sdram_cke}, 32'd0);
      check("rst_en", {29'b0, ar_en, wr_en, rd_en}, 32'd0);
      check("rst_tmo", {31'b0, arb_timeout}, 32'd0);
      check("rst_oe", {31'b0, sdram_dq_oe}, 32'd0);
      check("rst_dq", {16'b0, sdram_dq_out}, 32'd0);

      // Release reset; INIT follows init bus, cke from cycle 1
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      tick();
      check("cke_c1", {31'b0, sdram_cke}, 32'd1);
      check_pins("init_c1", 4'b0010, 2'b01, 12'h400);
      repeat (19) tick();
      check_pins("init_c20", 4'b0010, 2'b01, 12'h400);
      init_done = 1'b1;
      tick();
      check_pins("arbit_c21", 4'b0111, 2'b11, 12'hFFF);

      // Simultaneous requests: refresh first
      ar_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      tick();
      check("grant_ar", {29'b0, ar_en, wr_en, rd_en}, 32'b100);
      check_pins("aref", 4'b0001, 2'b00, 12'h400);
      ar_req = 1'b0;
      tick();
      check("ar_en_pulse", {31'b0, ar_en}, 32'd0);
      check_pins("aref_hold", 4'b0001, 2'b00, 12'h400);
      ar_end = 1'b1;
      tick();
      ar_end = 1'b0;
      check_pins("after_ar_end", 4'b0111, 2'b11, 12'hFFF);
      check("no_grant_arbit", {29'b0, ar_en, wr_en, rd_en}, 32'd0);
      tick();
      check("grant_wr", {29'b0, ar_en, wr_en, rd_en}, 32'b010);
      check_pins("write", 4'b0100, 2'b10, 12'h0AB);
      wr_req = 1'b0;

      // DQ drive in WRITE
      wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
      #1;
      check("wr_oe", {31'b0, sdram_dq_oe}, 32'd1);
      check("wr_dq", {16'b0, sdram_dq_out}, 32'h0000A5A5);

      // Non-owner end ignored
      ar_end = 1'b1;
      tick();
      ar_end = 1'b0;
      check_pins("write_ignore_ar_end", 4'b0100, 2'b10, 12'h0AB);
      check("wr_en_pulse", {31'b0, wr_en}, 32'd0);
      wr_sdram_en = 1'b0;
      #1;
      check("wr_oe_off", {31'b0, sdram_dq_oe}, 32'd0);
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
      check_pins("after_wr_end", 4'b0111, 2'b11, 12'hFFF);
      check("rd_en_early", {31'b0, rd_en}, 32'd0);
      tick();
      check("grant_rd", {29'b0, ar_en, wr_en, rd_en}, 32'b001);
      check_pins("read", 4'b0101, 2'b01, 12'h0CD);
      rd_req = 1'b0;

      // DQ stays off in READ
      wr_sdram_en = 1'b1;
      #1;
      check("rd_oe", {31'b0, sdram_dq_oe}, 32'd0);
      check("rd_dq", {16'b0, sdram_dq_out}, 32'd0);
      wr_sdram_en = 1'b0;

      // Refresh request mid-read waits for rd_end
      repeat (2) tick();
      ar_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ar_wait_en", {31'b0, ar_en}, 32'd0);
         check("ar_wait_cmd", {28'b0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 32'b0101);
      end
      rd_end = 1'b1;
      tick();
      rd_end = 1'b0;
      check_pins("after_rd_end", 4'b0111, 2'b11, 12'hFFF);
      check("ar_en_arbit", {31'b0, ar_en}, 32'd0);
      tick();
      check("grant_ar2", {31'b0, ar_en}, 32'd1);
      check_pins("aref2", 4'b0001, 2'b00, 12'h400);
      ar_req = 1'b0;
      ar_end = 1'b1;
      tick();
      ar_end = 1'b0;

      // Timeout on a write that never ends
      wr_req = 1'b1;
      tick();
      check("grant_wr_tmo", {31'b0, wr_en}, 32'd1);
      wr_req = 1'b0;
      repeat (2047) tick();
      check("tmo_before", {31'b0, arb_timeout}, 32'd0);
      check("tmo_before_cmd", {28'b0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 32'b0100);
      tick();
      check("tmo_pulse", {31'b0, arb_timeout}, 32'd1);
      check_pins("tmo_release", 4'b0111, 2'b11, 12'hFFF);
      tick();
      check("tmo_single", {31'b0, arb_timeout}, 32'd0);

      // wr_end coinciding with the timeout cycle wins
      wr_req = 1'b1;
      tick();
      check("grant_wr_end_win", {31'b0, wr_en}, 32'd1);
      wr_req = 1'b0;
      repeat (2047) tick();
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
      check("end_wins_tmo", {31'b0, arb_timeout}, 32'd0);
      check_pins("end_wins_pins", 4'b0111, 2'b11, 12'hFFF);
      tick();
      check("end_wins_tmo2", {31'b0, arb_timeout}, 32'd0);

      // init_done loss returns to INIT
      rd_req = 1'b1;
      tick();
      check("grant_rd2", {31'b0, rd_en}, 32'd1);
      init_done = 1'b0;
      tick();
      check_pins("init_drop", 4'b0010, 2'b01, 12'h400);
      check("init_drop_en", {29'b0, ar_en, wr_en, rd_en}, 32'd0);
      tick();
      check("init_hold_en", {31'b0, rd_en}, 32'd0);
      init_done = 1'b1;
      tick();
      check_pins("reinit_arbit", 4'b0111, 2'b11, 12'hFFF);
      tick();
      check("grant_rd3", {31'b0, rd_en}, 32'd1);
      rd_req = 1'b0;
      rd_end = 1'b1;
      tick();
      rd_end = 1'b0;

      // Reset mid-AREF
      ar_req = 1'b1;
      tick();
      check("grant_ar3", {31'b0, ar_en}, 32'd1);
      sys_rst_n = 1'b0;
      #1;
      check_pins("rst_mid", 4'b0111, 2'b11, 12'hFFF);
      check("rst_mid_en", {29'b0, ar_en, wr_en, rd_en}, 32'd0);
      check("rst_mid_cke", {31'b0, sdram_cke}, 32'd0);
      init_done = 1'b0;
      tick();
      sys_rst_n = 1'b1;
      tick();
      check("rel_cke", {31'b0, sdram_cke}, 32'd1);
      check_pins("rel_init", 4'b0010, 2'b01, 12'h400);
      repeat (3) tick();
      check("rel_no_grant", {29'b0, ar_en, wr_en, rd_en}, 32'd0);
      check_pins("rel_wait_init", 4'b0010, 2'b01, 12'h400);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
